scroll_engine: RTL
==================

# scroll_engine

Parametrised marquee engine driving an N-digit seven-segment bank and an LED progress bar on the DE1-SoC. It replaces hard-coded per-character display states with a loadable message buffer, programmable length, scroll direction, hold and repeat count. It sits between the step-tick divider and the HEX/LEDR pins.

## Interface
- NUM_DIGITS, 6: seven-segment digits driven (1..8)
- MSG_LEN, 16: message buffer depth in characters (2..64)
- NUM_LEDS, 10: progress-bar LEDs (1..16)
- LOOPS, 3: full message passes before DONE (1..255)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a run
- step  in  1  one-cycle scroll tick from external divider
- hold  in  1  freeze scrolling while high
- dir  in  1  0: char enters digit 0, shifts toward digit N-1; 1: enters digit N-1, shifts toward digit 0
- msg_len  in  $clog2(MSG_LEN+1)  active message length in characters
- wr_en  in  1  message buffer write strobe
- wr_addr  in  $clog2(MSG_LEN)  buffer write address
- wr_data  in  7  segment pattern, active-low
- hex  out  7*NUM_DIGITS  digit i on [7i+6:7i], active-low
- ledr  out  NUM_LEDS  completed-pass thermometer
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start

## Operation
- States: IDLE, SCROLL, GAP, DONE.
- IDLE: hex all HEX_OFF (7'h7F), busy=0, done=0.
- start accepted in IDLE or DONE only, and only if 1 <= msg_len <= MSG_LEN; otherwise ignored. msg_len is latched at accept. On accept: hex cleared to HEX_OFF, ledr cleared, char index=0, pass=0, done=0, busy=1, go SCROLL.
- SCROLL, on step && !hold: shift buffer[index] into entry digit per dir (others shift one place, exit digit discarded); index++. When the shifted char was index latched_len-1: go GAP, gap count=0.
- GAP, on step && !hold: shift HEX_OFF in; gap++. After NUM_DIGITS blanks (display fully blank): pass++, ledr = thermometer(min(pass, NUM_LEDS)); if pass==LOOPS go DONE, else index=0, go SCROLL.
- DONE: busy=0, done=1, hex all HEX_OFF, ledr holds final value.
- Buffer writes accepted only when busy=0; ignored while busy. wr_addr >= MSG_LEN ignored.
- dir sampled on every step; changing it mid-run is legal and affects only subsequent shifts.

## Timing
- All outputs registered. Reset values: hex all 7'h7F, ledr 0, busy 0, done 0, state IDLE. Reset acts immediately, mid-run included. Buffer contents are not reset: undefined at power-up, preserved across reset.
- step at cycle t -> new hex/ledr/state visible at t+1.
- start accepted at t -> busy=1 at t+1; a step in the same cycle as start is ignored.
- step while hold=1 is dropped, not queued.
- Steps per pass = L + NUM_DIGITS (L = latched length); total run = LOOPS*(L+NUM_DIGITS) steps; done=1 the cycle after the final step.
- Write at t is readable by a start at t+1.

## Structure
- Package scroll_pkg: HEX_OFF and glyph constants (HEX_C, HEX_P, HEX_E, HEX_N, HEX_3, HEX_1, HEX_b, HEX_y, HEX_e), typedef enum logic[1:0] scroll_state_t {IDLE, SCROLL, GAP, DONE}.
- Sub-module seg_shift_reg: NUM_DIGITS x 7 bidirectional shift register with load_blank, shift_en, dir and data_in. It has async active-low reset to HEX_OFF.
- Top holds the FSM, buffer (flop array, no reset), index/gap/pass counters, and thermometer encode.

## Test plan
- Reset mid-SCROLL (pass 1, index 3), then release -> hex=all 7'h7F, ledr=0, busy=0 while reset low; buffer still holds "CPEN".
- Load "CPEN", msg_len=4, LOOPS=1, dir=0, 10 steps -> after step 4 hex5..hex0 = OFF,OFF,C,P,E,N; after step 10 all OFF; done=1, ledr=10'b1.
- Same message, dir=1 -> after step 4 hex0..hex5 = OFF,OFF,C,P,E,N. Toggle dir at step 2 -> shift direction changes from step 3 onward.
- hold=1 across 5 steps mid-run -> hex unchanged; on release, next step advances exactly one position; total step count to done = 10 + 5.
- LOOPS=12, NUM_LEDS=10, msg_len=1 -> ledr fills one bit per 7 steps and saturates at 10'h3FF; done after 84 steps. start during run, and wr_en during run -> both ignored.
- msg_len=0 or msg_len=17 with start -> stays IDLE, busy=0. start and step in the same cycle -> busy=1, hex unchanged.

Source files
------------

// File: rtl/scroll_pkg.sv
// ---------------------------------------------------------------
// scroll_pkg: glyph constants and FSM state type -- rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package scroll_pkg;

  // Active-low seven-segment patterns, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] HEX_OFF = 7'h7F;
  localparam logic [6:0] HEX_C   = 7'h46;
  localparam logic [6:0] HEX_P   = 7'h0C;
  localparam logic [6:0] HEX_E   = 7'h06;
  localparam logic [6:0] HEX_N   = 7'h2B;
  localparam logic [6:0] HEX_3   = 7'h30;
  localparam logic [6:0] HEX_1   = 7'h79;
  localparam logic [6:0] HEX_b   = 7'h03;
  localparam logic [6:0] HEX_y   = 7'h11;
  localparam logic [6:0] HEX_e   = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } scroll_state_t;

endpackage

`default_nettype wire

// File: rtl/seg_shift_reg.sv
// ---------------------------------------------------------------
// seg_shift_reg: NUM_DIGITS x 7 bidirectional digit shifter -- rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module seg_shift_reg
  import scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_blank_i,
  input  logic                    shift_en_i,
  input  logic                    dir_i,
  input  logic [6:0]              data_i,
  output logic [7*NUM_DIGITS-1:0] hex_o
);

  localparam int W = 7 * NUM_DIGITS;

  logic [W-1:0] hex_q;
  logic [W-1:0] shift_up;
  logic [W-1:0] shift_dn;

  generate
    if (NUM_DIGITS == 1) begin : g_single
      assign shift_up = data_i;
      assign shift_dn = data_i;
    end else begin : g_multi
      // dir=0 enters at digit 0 (LSBs), dir=1 enters at digit N-1 (MSBs)
      assign shift_up = {hex_q[W-8:0], data_i};
      assign shift_dn = {data_i, hex_q[W-1:7]};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hex_q <= {NUM_DIGITS{HEX_OFF}};
    end else if (load_blank_i) begin
      hex_q <= {NUM_DIGITS{HEX_OFF}};
    end else if (shift_en_i) begin
      hex_q <= dir_i ? shift_dn : shift_up;
    end
  end

  assign hex_o = hex_q;

endmodule

`default_nettype wire

// File: rtl/scroll_engine.sv
// ---------------------------------------------------------------
// scroll_engine: looping seven-segment marquee with progress bar -- rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module scroll_engine
  import scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 16,
  parameter int NUM_LEDS   = 10,
  parameter int LOOPS      = 3,
  localparam int LEN_W     = $clog2(MSG_LEN + 1),
  localparam int ADDR_W    = $clog2(MSG_LEN)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    step_i,
  input  logic                    hold_i,
  input  logic                    dir_i,
  input  logic [LEN_W-1:0]        msg_len_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [6:0]              wr_data_i,
  output logic [7*NUM_DIGITS-1:0] hex_o,
  output logic [NUM_LEDS-1:0]     ledr_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int GAP_W = $clog2(NUM_DIGITS + 1);

  scroll_state_t        state_q;
  logic [LEN_W-1:0]     len_q;
  logic [ADDR_W-1:0]    idx_q;
  logic [GAP_W-1:0]     gap_q;
  logic [7:0]           pass_q;
  logic [7:0]           pass_d;
  logic [NUM_LEDS-1:0]  ledr_q;
  logic [NUM_LEDS-1:0]  therm_d;
  logic                 busy_q;
  logic                 done_q;
  logic [6:0]           buf_q [MSG_LEN];

  logic                 adv;
  logic                 len_ok;
  logic                 accept;
  logic                 last_char;
  logic                 last_gap;
  logic                 shift_en;
  logic [6:0]           seg_in;

  assign adv       = step_i && !hold_i;
  assign len_ok    = (msg_len_i != '0) && (int'(msg_len_i) <= MSG_LEN);
  assign accept    = start_i && len_ok && ((state_q == IDLE) || (state_q == DONE));
  assign last_char = (int'(idx_q) == int'(len_q) - 1);
  assign last_gap  = (int'(gap_q) == NUM_DIGITS - 1);
  assign pass_d    = pass_q + 8'd1;
  assign shift_en  = adv && ((state_q == SCROLL) || (state_q == GAP));
  assign seg_in    = (state_q == SCROLL) ? buf_q[idx_q] : HEX_OFF;

  // Saturating thermometer of the pass count that is about to complete
  always_comb begin
    therm_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      therm_d[i] = (int'(pass_d) > i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_q && (int'(wr_addr_i) < MSG_LEN)) begin
      buf_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      pass_q  <= '0;
      ledr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q <= SCROLL;
            len_q   <= msg_len_i;
            idx_q   <= '0;
            pass_q  <= '0;
            ledr_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        SCROLL: begin
          if (adv) begin
            if (last_char) begin
              state_q <= GAP;
              gap_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (adv) begin
            if (last_gap) begin
              pass_q <= pass_d;
              ledr_q <= therm_d;
              if (int'(pass_d) == LOOPS) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= SCROLL;
                idx_q   <= '0;
              end
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  seg_shift_reg #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_seg_shift_reg (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_blank_i (accept),
    .shift_en_i   (shift_en),
    .dir_i        (dir_i),
    .data_i       (seg_in),
    .hex_o        (hex_o)
  );

  assign ledr_o = ledr_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

`default_nettype wire
